// File: rtl/jk_bank_arbiter.sv
// jk_bank_arbiter
//   Bank of N JK flip-flop cells that two requesters share. A round-robin
//   arbiter serialises single-cell J/K commands. Each command takes three
//   cycles: IDLE (grant), APPLY (cell update), ACK (acknowledge with new Q).
//
// Ports
//   Clk              clock, all state changes on rising edge
//   rst              synchronous active-high reset
//   req0/idx0/j0/k0  requester 0 command (held until ack0)
//   ack0             one-cycle acknowledge to requester 0
//   req1/idx1/j1/k1  requester 1 command (held until ack1)
//   ack1             one-cycle acknowledge to requester 1
//   rdata            new Q of the served cell, valid while an ack is high
//   err              served index was >= N, valid while an ack is high
//   busy             arbiter not in IDLE
//   q                current state of all cells
module jk_bank_arbiter #(
  parameter int N  = 6,
  parameter int IW = 3
) (
  input  logic          Clk,
  input  logic          rst,
  input  logic          req0,
  input  logic [IW-1:0] idx0,
  input  logic          j0,
  input  logic          k0,
  output logic          ack0,
  input  logic          req1,
  input  logic [IW-1:0] idx1,
  input  logic          j1,
  input  logic          k1,
  output logic          ack1,
  output logic          rdata,
  output logic          err,
  output logic          busy,
  output logic [N-1:0]  q
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_APPLY = 2'd1;
  localparam logic [1:0] S_ACK   = 2'd2;

  // Cell count widened by one bit so idx comparisons need no truncation.
  localparam logic [IW:0] N_LIM = (IW+1)'(N);

  logic [1:0]    state;
  logic          gnt_id;     // requester being served
  logic          last_srv;   // requester served most recently
  logic [IW-1:0] idx_r;
  logic          j_r;
  logic          k_r;
  logic          err_r;

  logic          grant_valid;
  logic          grant_id;
  logic          in_range;
  logic          q_sel;

  // On a tie the requester that was not served last wins.
  always_comb begin
    grant_valid = req0 | req1;
    if (req0 && req1) grant_id = ~last_srv;
    else              grant_id = req1;
  end

  always_comb begin
    in_range = ({1'b0, idx_r} < N_LIM);
  end

  // Read mux written as a decode loop so out-of-range idx never indexes q.
  always_comb begin
    q_sel = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      if (idx_r == IW'(i)) q_sel = q[i];
    end
  end

  always_ff @(posedge Clk) begin
    if (rst) begin
      state    <= S_IDLE;
      q        <= '0;
      gnt_id   <= 1'b0;
      last_srv <= 1'b1;
      idx_r    <= '0;
      j_r      <= 1'b0;
      k_r      <= 1'b0;
      err_r    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (grant_valid) begin
            gnt_id <= grant_id;
            idx_r  <= grant_id ? idx1 : idx0;
            j_r    <= grant_id ? j1   : j0;
            k_r    <= grant_id ? k1   : k0;
            state  <= S_APPLY;
          end
        end
        S_APPLY: begin
          if (in_range) begin
            for (int unsigned i = 0; i < N; i++) begin
              if (idx_r == IW'(i)) q[i] <= (j_r & ~q[i]) | (~k_r & q[i]);
            end
            err_r <= 1'b0;
          end else begin
            err_r <= 1'b1;
          end
          last_srv <= gnt_id;
          state    <= S_ACK;
        end
        S_ACK: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // Outputs decode registered state only; they read 0 outside ACK.
  always_comb begin
    busy  = (state != S_IDLE);
    ack0  = (state == S_ACK) & ~gnt_id;
    ack1  = (state == S_ACK) &  gnt_id;
    err   = (state == S_ACK) &  err_r;
    rdata = (state == S_ACK) & ~err_r & q_sel;
  end

endmodule

// File: tb/tb_jk_bank_arbiter.sv
// tb_jk_bank_arbiter
//   Directed bench for jk_bank_arbiter (N=6, IW=3) with hand-computed
//   expected values: reset state, single-command latency, JK truth table,
//   tie fairness, out-of-range indices and reset during APPLY.
module tb_jk_bank_arbiter;

  logic       Clk = 1'b0;
  logic       rst;
  logic       req0, j0, k0, ack0;
  logic [2:0] idx0;
  logic       req1, j1, k1, ack1;
  logic [2:0] idx1;
  logic       rdata, err, busy;
  logic [5:0] q;

  int n_checks = 0;
  int n_errors = 0;

  jk_bank_arbiter #(.N(6), .IW(3)) dut (
    .Clk  (Clk),
    .rst  (rst),
    .req0 (req0),
    .idx0 (idx0),
    .j0   (j0),
    .k0   (k0),
    .ack0 (ack0),
    .req1 (req1),
    .idx1 (idx1),
    .j1   (j1),
    .k1   (k1),
    .ack1 (ack1),
    .rdata(rdata),
    .err  (err),
    .busy (busy),
    .q    (q)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Advance to the next cycle; inputs set and outputs sampled 1 time unit after the edge.
  task automatic tick;
    @(posedge Clk);
    #1;
  endtask

  task automatic do_reset;
    rst  = 1'b1;
    req0 = 1'b0; idx0 = '0; j0 = 1'b0; k0 = 1'b0;
    req1 = 1'b0; idx1 = '0; j1 = 1'b0; k1 = 1'b0;
    tick;
    tick;
    rst = 1'b0;
  endtask

  // Issue one command, wait (bounded) for its ack, check result, then drop req.
  task automatic issue(input string tag, input logic r, input logic [2:0] idx,
                       input logic j, input logic k,
                       input logic exp_rd, input logic exp_er);
    int cyc;
    if (r) begin req1 = 1'b1; idx1 = idx; j1 = j; k1 = k; end
    else   begin req0 = 1'b1; idx0 = idx; j0 = j; k0 = k; end
    cyc = 0;
    do begin
      tick;
      cyc++;
    end while (!(r ? ack1 : ack0) && cyc < 10);
    check({tag, "_latency"}, cyc, 2);
    check({tag, "_rdata"}, rdata, exp_rd);
    check({tag, "_err"}, err, exp_er);
    check({tag, "_other_ack"}, r ? ack0 : ack1, 0);
    tick;
    if (r) req1 = 1'b0; else req0 = 1'b0;
  endtask

  logic [2:0] jk_j [6];
  logic [2:0] jk_k [6];

  initial begin
    // ---------------- reset state ----------------
    do_reset;
    check("rst_q", q, 6'b000000);
    check("rst_busy", busy, 0);
    check("rst_ack0", ack0, 0);
    check("rst_ack1", ack1, 0);
    check("rst_rdata", rdata, 0);
    check("rst_err", err, 0);

    // ---------------- single command, exact cycles ----------------
    tick;                                   // cycle 1
    req0 = 1'b1; idx0 = 3'd2; j0 = 1'b1; k0 = 1'b0;
    check("c1_busy", busy, 0);
    tick;                                   // cycle 2: APPLY
    check("c2_busy", busy, 1);
    check("c2_ack0", ack0, 0);
    check("c2_q", q, 6'b000000);
    tick;                                   // cycle 3: ACK
    check("c3_busy", busy, 1);
    check("c3_ack0", ack0, 1);
    check("c3_ack1", ack1, 0);
    check("c3_rdata", rdata, 1);
    check("c3_err", err, 0);
    check("c3_q", q, 6'b000100);
    tick;                                   // cycle 4: IDLE
    req0 = 1'b0;
    check("c4_busy", busy, 0);
    check("c4_ack0", ack0, 0);
    tick;
    check("c5_busy", busy, 0);

    // ---------------- JK truth table on cell 5 via req1 ----------------
    do_reset;
    begin
      logic [5:0] exp_q [6];
      logic       exp_rd [6];
      // (J,K): 00 10 00 11 11 01 -> Q: 0 1 1 0 1 0
      jk_j[0] = 0; jk_k[0] = 0; exp_rd[0] = 0;
      jk_j[1] = 1; jk_k[1] = 0; exp_rd[1] = 1;
      jk_j[2] = 0; jk_k[2] = 0; exp_rd[2] = 1;
      jk_j[3] = 1; jk_k[3] = 1; exp_rd[3] = 0;
      jk_j[4] = 1; jk_k[4] = 1; exp_rd[4] = 1;
      jk_j[5] = 0; jk_k[5] = 1; exp_rd[5] = 0;
      exp_q[0] = 6'b000000; exp_q[1] = 6'b100000; exp_q[2] = 6'b100000;
      exp_q[3] = 6'b000000; exp_q[4] = 6'b100000; exp_q[5] = 6'b000000;
      for (int i = 0; i < 6; i++) begin
        issue($sformatf("jk%0d", i), 1'b1, 3'd5, jk_j[i][0], jk_k[i][0], exp_rd[i], 1'b0);
        check($sformatf("jk%0d_q", i), q, exp_q[i]);
      end
    end

    // ---------------- tie and fairness ----------------
    do_reset;
    tick;                                   // cycle 1
    req0 = 1'b1; idx0 = 3'd0; j0 = 1'b1; k0 = 1'b1;
    req1 = 1'b1; idx1 = 3'd1; j1 = 1'b1; k1 = 1'b1;
    for (int c = 2; c <= 12; c++) begin
      logic e0, e1;
      tick;
      e0 = (c == 3) || (c == 9);
      e1 = (c == 6) || (c == 12);
      check($sformatf("tie_c%0d_ack0", c), ack0, e0);
      check($sformatf("tie_c%0d_ack1", c), ack1, e1);
      check($sformatf("tie_c%0d_both", c), ack0 & ack1, 0);
      // Each cell toggles: first service gives 1, second gives 0.
      if (c == 3)  check("tie_c3_rdata", rdata, 1);
      if (c == 6)  check("tie_c6_rdata", rdata, 1);
      if (c == 9)  check("tie_c9_rdata", rdata, 0);
      if (c == 12) check("tie_c12_rdata", rdata, 0);
    end
    tick;                                   // cycle 13: IDLE
    req0 = 1'b0; req1 = 1'b0;
    check("tie_q", q, 6'b000000);
    tick;
    check("tie_idle_busy", busy, 0);

    // ---------------- out of range ----------------
    do_reset;
    issue("oor7", 1'b0, 3'd7, 1'b1, 1'b0, 1'b0, 1'b1);
    check("oor7_q", q, 6'b000000);
    issue("oor6", 1'b1, 3'd6, 1'b1, 1'b0, 1'b0, 1'b1);
    check("oor6_q", q, 6'b000000);
    issue("inr5", 1'b0, 3'd5, 1'b1, 1'b0, 1'b1, 1'b0);
    check("inr5_q", q, 6'b100000);

    // ---------------- reset during APPLY ----------------
    do_reset;
    tick;                                   // cycle 1
    req0 = 1'b1; idx0 = 3'd1; j0 = 1'b1; k0 = 1'b0;
    tick;                                   // cycle 2: APPLY
    check("mid_apply_busy", busy, 1);
    rst = 1'b1;
    tick;                                   // cycle 3
    check("mid_q", q, 6'b000000);
    check("mid_ack0", ack0, 0);
    check("mid_busy", busy, 0);
    rst = 1'b0;
    begin
      int cyc;
      cyc = 0;
      do begin
        tick;
        cyc++;
      end while (!ack0 && cyc < 10);
      check("mid_retry_latency", cyc, 2);
      check("mid_retry_rdata", rdata, 1);
      check("mid_retry_err", err, 0);
      check("mid_retry_q", q, 6'b000010);
    end
    tick;
    req0 = 1'b0;
    tick;
    check("end_busy", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
